// File: rtl/uart_line_loader_pkg.sv
// Shared constants, state encoding and hex decode helper for the UART line loader.
package uart_loader_pkg;

    localparam logic [7:0] CH_COMMIT = 8'h2B;  // '+'
    localparam logic [7:0] CH_FRAME  = 8'h23;  // '#'
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_SP     = 8'h20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2
    } loader_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_t;

    function automatic hex_t hex_nibble(input logic [7:0] c);
        hex_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.nibble = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 4'hA
            r.nibble = c[3:0] + 4'd9;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_line_loader_if.sv
// Line-BRAM write bus: the loader drives it (master), the BRAM consumes it (slave).
interface uart_line_loader_if #(
    parameter int LINE_BITS = 300,
    parameter int ADDR_W    = 10
);
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [LINE_BITS-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_line_loader_rx_byte_strobe.sv
// Turns the level-style uart_rx READY into a single-cycle byte strobe; while en is low
// the history holds, so an edge arriving then is seen once en returns.
module rx_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);
    logic ready_hist;

    always_ff @(posedge clk) begin
        if (rst)
            ready_hist <= 1'b0;
        else if (en)
            ready_hist <= rx_ready;
    end

    assign byte_valid = en & rx_ready & ~ready_hist;
    assign rx_byte    = rx_data;
endmodule

// File: rtl/uart_line_loader.sv
// ASCII-hex line loader: assembles LINE_BITS-wide lines from hex digits and commits them to BRAM.
// Optional macro AUTO_COMMIT_EN: commit automatically once DIGITS digits are held.
module uart_line_loader
    import uart_loader_pkg::*;
#(
    parameter int LINE_BITS = 300,
    parameter int LINES     = 608,
    parameter int ADDR_W    = 10,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    uart_line_loader_if.master wr_bus,
    output logic [ADDR_W-1:0] line_idx,
    output logic              frame_done,
    output logic              overflow,
    output logic [ERR_W-1:0]  err_count
);
    localparam int DIGITS = (LINE_BITS + 3) / 4;
    localparam int IDX_W  = $clog2(DIGITS + 1);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_DECODE = 2'(DECODE);
    localparam logic [1:0] S_COMMIT = 2'(COMMIT);

    logic [1:0]           state_q, cur_state;
    logic                 byte_valid;
    logic [7:0]           rx_byte;
    hex_t                 hx;
    logic [LINE_BITS-1:0] line_buf, digit_buf, commit_data;
    logic [IDX_W-1:0]     digit_idx;
    logic                 wr_en_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [LINE_BITS-1:0] wr_data_q;
    logic                 decoding, is_digit, is_commit_ch, is_frame, is_bad;
    logic                 room, take_digit, commit, set_overflow;
`ifdef AUTO_COMMIT_EN
    logic                 auto_commit, just_auto;
`endif

    rx_byte_strobe u_strobe (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q != S_COMMIT),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte)
    );

    // DECODE is the edge cycle itself: the byte is classified and acted on at its closing edge.
    always_comb begin
        cur_state = S_IDLE;
        if (state_q == S_COMMIT)
            cur_state = S_COMMIT;
        else if (byte_valid)
            cur_state = S_DECODE;
    end

    assign hx           = hex_nibble(rx_byte);
    assign decoding     = (cur_state == S_DECODE);
    assign is_digit     = decoding && hx.valid;
    assign is_commit_ch = decoding && (rx_byte == CH_COMMIT);
    assign is_frame     = decoding && (rx_byte == CH_FRAME);
    assign is_bad       = decoding && !hx.valid && (rx_byte != CH_COMMIT) && (rx_byte != CH_FRAME)
                          && (rx_byte != CH_CR) && (rx_byte != CH_LF) && (rx_byte != CH_SP);
    assign room         = (digit_idx < IDX_W'(DIGITS));
    assign take_digit   = is_digit && room;

    // NOTE: digit_buf is given its full default first so this always_comb never infers a latch.
    always_comb begin
        digit_buf = line_buf;
        for (int p = 0; p < LINE_BITS; p++) begin
            if (p / 4 == int'(digit_idx))
                digit_buf[p] = hx.nibble[p % 4];
        end
    end

`ifdef AUTO_COMMIT_EN
    assign auto_commit  = take_digit && (digit_idx == IDX_W'(DIGITS - 1));
    assign commit       = auto_commit || (is_commit_ch && !just_auto);
    assign commit_data  = auto_commit ? digit_buf : line_buf;
    assign set_overflow = 1'b0;
`else
    assign commit       = is_commit_ch;
    assign commit_data  = line_buf;
    assign set_overflow = is_digit && !room;
`endif

    // NOTE: every register, the line buffer included, is ordinary flops, so all take the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_done <= 1'b0;
            line_idx   <= '0;
            line_buf   <= '0;
            digit_idx  <= '0;
            overflow   <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= commit ? S_COMMIT : S_IDLE;
            wr_en_q    <= commit;
            frame_done <= commit && (line_idx == ADDR_W'(LINES - 1));
            if (commit) begin
                wr_addr_q <= line_idx;
                wr_data_q <= commit_data;
                line_buf  <= '0;
                digit_idx <= '0;
                line_idx  <= (line_idx == ADDR_W'(LINES - 1)) ? '0 : line_idx + 1'b1;
            end else if (take_digit) begin
                line_buf  <= digit_buf;
                digit_idx <= digit_idx + 1'b1;
            end
            if (is_frame) begin
                line_idx  <= '0;
                line_buf  <= '0;
                digit_idx <= '0;
                overflow  <= 1'b0;
            end
            if (set_overflow)
                overflow <= 1'b1;
            if (is_bad && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

`ifdef AUTO_COMMIT_EN
    // Remembers that the line just went out on its own, so a trailing '+' is not a second write.
    always_ff @(posedge clk) begin
        if (rst)
            just_auto <= 1'b0;
        else if (auto_commit)
            just_auto <= 1'b1;
        else if (take_digit || is_frame || is_commit_ch)
            just_auto <= 1'b0;
    end
`endif

    assign wr_bus.wr_en   = wr_en_q;
    assign wr_bus.wr_addr = wr_addr_q;
    assign wr_bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_uart_line_loader.sv
// Directed bench for uart_line_loader (LINE_BITS=14 -> 4 digits, LINES=4); honours AUTO_COMMIT_EN.
module tb_uart_line_loader;
    localparam int LINE_BITS = 14;
    localparam int LINES     = 4;
    localparam int ADDR_W    = 10;
    localparam int ERR_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_ready = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic [ADDR_W-1:0] line_idx;
    logic              frame_done;
    logic              overflow;
    logic [ERR_W-1:0]  err_count;

    int checks = 0;
    int errors = 0;

    int                   wr_cnt = 0;
    int                   dbl_wr = 0;
    int                   stray_fd = 0;
    int                   fd_cnt = 0;
    logic                 prev_wr = 1'b0;
    logic [ADDR_W-1:0]    last_addr = '0;
    logic [LINE_BITS-1:0] last_data = '0;
    logic                 last_fd = 1'b0;
    int                   exp_wr = 0;

    uart_line_loader_if #(.LINE_BITS(LINE_BITS), .ADDR_W(ADDR_W)) wr_bus ();

    uart_line_loader #(
        .LINE_BITS (LINE_BITS),
        .LINES     (LINES),
        .ADDR_W    (ADDR_W),
        .ERR_W     (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .wr_bus     (wr_bus),
        .line_idx   (line_idx),
        .frame_done (frame_done),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_bus.wr_en && prev_wr) dbl_wr++;
        prev_wr = wr_bus.wr_en;
        if (frame_done && !wr_bus.wr_en) stray_fd++;
        if (wr_bus.wr_en) begin
            wr_cnt++;
            last_addr = wr_bus.wr_addr;
            last_data = wr_bus.wr_data;
            last_fd   = frame_done;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b);
    endtask

    task automatic check_commit(input string tag, input logic [ADDR_W-1:0] addr,
                                input logic [LINE_BITS-1:0] data);
        exp_wr++;
        check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
        check({tag, "_addr"}, 32'(last_addr), 32'(addr));
        check({tag, "_data"}, 32'(last_data), 32'(data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_bus.wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_bus.wr_data), 0);
        check({tag, "_line_idx"}, 32'(line_idx), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic line: digits fill from bit 0 upward.
        send_byte("#");
        send_byte("1");
        send_byte("a");
        send_byte("F");
        send_byte("+");
        check_commit("basic", 10'd0, 14'h0FA1);
        check("basic_line_idx", 32'(line_idx), 1);

        // Level-held READY must accept the byte only once.
        rx_data  = "3";
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        send_byte("+");
        check_commit("held", 10'd1, 14'h0003);

        // Empty commits up to the last line, then wrap with frame_done.
        send_byte("+");
        check_commit("line2", 10'd2, 14'h0000);
        check("line2_fd_cnt", fd_cnt, 0);
        send_byte("+");
        check_commit("line3", 10'd3, 14'h0000);
        check("line3_fd", 32'(last_fd), 1);
        check("line3_fd_cnt", fd_cnt, 1);
        check("wrap_line_idx", 32'(line_idx), 0);

        // Digit-count limit.
        send_byte("#");
`ifdef AUTO_COMMIT_EN
        send_n("7", 4);
        check_commit("auto", 10'd0, 14'h3777);
        send_byte("7");
        send_byte("+");
        check_commit("auto_next", 10'd1, 14'h0007);
        check("auto_overflow", 32'(overflow), 0);
        send_byte("#");
        send_n("1", 4);
        check_commit("auto2", 10'd0, 14'h1111);
        send_byte("+");
        check("auto_plus_no_write", wr_cnt, exp_wr);
        check("auto_plus_line_idx", 32'(line_idx), 1);
`else
        send_n("7", 5);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_no_write", wr_cnt, exp_wr);
        send_byte("+");
        check_commit("ovf", 10'd0, 14'h3777);
        check("ovf_sticky", 32'(overflow), 1);
`endif
        send_byte("#");
        check("frame_clears_ovf", 32'(overflow), 0);
        check("frame_line_idx", 32'(line_idx), 0);

        // Bad characters count and saturate; whitespace is ignored.
        send_byte("G");
        send_byte("z");
        send_byte(8'h00);
        check("err_three", 32'(err_count), 3);
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(" ");
        check("ws_err", 32'(err_count), 3);
        check("ws_line_idx", 32'(line_idx), 0);
        check("ws_no_write", wr_cnt, exp_wr);
        for (int i = 0; i < 300; i++) send_byte(8'h80 + 8'(i % 16));
        check("err_saturate", 32'(err_count), 255);

        // Reset in the middle of a line.
        send_byte("#");
        send_byte("5");
        send_byte("6");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        send_byte("+");
        check_commit("post_rst", 10'd0, 14'h0000);
        check("post_rst_line_idx", 32'(line_idx), 1);

        check("no_back_to_back_wr", dbl_wr, 0);
        check("no_stray_frame_done", stray_fd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
